seg_scan_decoder: RTL and testbench

Receive-side decoder for the multiplexed 7-segment display bus (`an`/`seg`) driven by the junction traffic-light controller. It samples the anode strobe and active-low segment lines, waits for each strobe/pattern pair to settle, and decodes the pattern back to BCD. It holds one digit per anode position and reports per-digit validity, pattern/strobe errors and loss of refresh. It serves as an on-chip display self-check and as the front end for mirroring the countdown onto a remote display.

---
 rtl/seg_dec_pkg.sv | 48 ++++
 rtl/seg7_pattern_decode.sv | 42 ++++
 rtl/seg_scan_decoder.sv | 184 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_dec_pkg.sv
// ============================================================================
//  Module      : seg_dec_pkg
//  Description : Shared constants and FSM state type for the 7-segment scan
//                decoder (active-low a..g patterns, blank code, state enum).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_dec_pkg;

    // Active-low a..g patterns, identical to the display encoder's table
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } seg_dec_state_t;

    // Anode bit to digit position: an[3] is the ones digit (position 0)
    function automatic logic [1:0] an_to_pos(input logic [3:0] an_oh);
        logic [1:0] pos;
        pos = 2'd0;
        case (an_oh)
            4'b1000: pos = 2'd0;
            4'b0100: pos = 2'd1;
            4'b0010: pos = 2'd2;
            4'b0001: pos = 2'd3;
            default: pos = 2'd0;
        endcase
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ============================================================================
//  Module      : seg7_pattern_decode
//  Description : Combinational active-low a..g pattern to BCD classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_pattern_decode
    import seg_dec_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_is_digit,
    output logic       o_is_blank,
    output logic [3:0] o_bcd
);

    always_comb begin
        o_is_digit = 1'b1;
        o_is_blank = 1'b0;
        o_bcd      = DIGIT_INVALID;
        case (i_pattern)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: begin
                o_is_digit = 1'b0;
                o_is_blank = 1'b1;
            end
            default:   o_is_digit = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Samples the multiplexed an/seg display bus, waits for each
//                strobe/pattern pair to settle and decodes it back to BCD per
//                anode position, with error pulses and a refresh watchdog.
//                Define SEG_DEC_SYNC_EN to add a 2-flop input synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder
    import seg_dec_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dig_valid,
    output logic [3:0]  dp_out,
    output logic        upd,
    output logic        err_pat,
    output logic        err_an,
    output logic        stale
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SCW-1:0] C_SETTLE_LAST = SCW'(STABLE_CYCLES - 1);
    localparam logic [TOW-1:0] C_WD_LAST     = TOW'(TIMEOUT_CYCLES - 1);
    localparam logic [TOW-1:0] C_WD_ARM      = TOW'(TIMEOUT_CYCLES - 2);

    logic [11:0]    w_bus;
    logic [11:0]    r_s;
    logic [SCW-1:0] r_settle_cnt;
    logic [TOW-1:0] r_wd_cnt;
    seg_dec_state_t r_state;

`ifdef SEG_DEC_SYNC_EN
    logic [11:0] r_sync1;
    logic [11:0] r_sync2;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {an, seg};
            r_sync2 <= r_sync1;
        end
    end

    assign w_bus = r_sync2;
`else
    assign w_bus = {an, seg};
`endif

    logic [3:0] w_an;
    logic [7:0] w_seg;
    logic [1:0] w_pos;
    logic       w_is_digit;
    logic       w_is_blank;
    logic [3:0] w_bcd;

    assign w_an  = r_s[11:8];
    assign w_seg = r_s[7:0];
    assign w_pos = an_to_pos(w_an);

    seg7_pattern_decode u_pattern_decode (
        .i_pattern  (w_seg[7:1]),
        .o_is_digit (w_is_digit),
        .o_is_blank (w_is_blank),
        .o_bcd      (w_bcd)
    );

    // A capture needs the bus to still match the sample on the terminal count
    logic w_bus_same;
    logic w_capture;

    assign w_bus_same = (w_bus == r_s);
    assign w_capture  = (r_state == SETTLE) && w_bus_same && (r_settle_cnt == C_SETTLE_LAST);

    logic [15:0] w_digits_nx;
    logic [3:0]  w_valid_nx;
    logic [3:0]  w_dp_nx;
    logic        w_cap_upd;
    logic        w_cap_err_pat;
    logic        w_cap_err_an;
    logic        w_valid_cap;
    logic [3:0]  w_old_digit;

    always_comb begin
        w_digits_nx   = digits;
        w_valid_nx    = dig_valid;
        w_dp_nx       = dp_out;
        w_cap_upd     = 1'b0;
        w_cap_err_pat = 1'b0;
        w_cap_err_an  = 1'b0;
        w_valid_cap   = 1'b0;
        w_old_digit   = digits[{w_pos, 2'b00} +: 4];
        if (w_capture) begin
            if (!$onehot0(w_an)) begin
                w_cap_err_an = 1'b1;
            end else if (w_an != 4'b0000) begin
                if (w_is_digit) begin
                    w_cap_upd   = !dig_valid[w_pos] || (w_old_digit != w_bcd);
                    w_digits_nx[{w_pos, 2'b00} +: 4] = w_bcd;
                    w_valid_nx[w_pos] = 1'b1;
                    w_dp_nx[w_pos]    = ~w_seg[0];
                    w_valid_cap       = 1'b1;
                end else begin
                    w_cap_upd     = dig_valid[w_pos];
                    w_digits_nx[{w_pos, 2'b00} +: 4] = DIGIT_INVALID;
                    w_valid_nx[w_pos] = 1'b0;
                    w_cap_err_pat = !w_is_blank;
                end
            end
        end
    end

    // Timeout fires on the cycle the watchdog reaches its last count; a valid
    // capture in that same cycle takes priority and restarts it
    logic w_timeout;
    assign w_timeout = !w_valid_cap && (r_wd_cnt >= C_WD_ARM);

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_s          <= '0;
            r_settle_cnt <= '0;
            r_wd_cnt     <= '0;
            r_state      <= WAIT;
            digits       <= {4{DIGIT_INVALID}};
            dig_valid    <= '0;
            dp_out       <= '0;
            upd          <= 1'b0;
            err_pat      <= 1'b0;
            err_an       <= 1'b0;
            stale        <= 1'b0;
        end else begin
            if (!w_bus_same) begin
                r_s          <= w_bus;
                r_settle_cnt <= '0;
                r_state      <= SETTLE;
            end else begin
                case (r_state)
                    SETTLE: begin
                        if (r_settle_cnt == C_SETTLE_LAST) begin
                            r_state <= HELD;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SCW'(1);
                        end
                    end
                    HELD:    r_state <= HELD;
                    default: r_state <= WAIT;
                endcase
            end

            digits  <= w_digits_nx;
            dp_out  <= w_dp_nx;
            err_pat <= w_cap_err_pat;
            err_an  <= w_cap_err_an;

            if (w_valid_cap) begin
                r_wd_cnt <= '0;
                stale    <= 1'b0;
            end else if (w_timeout) begin
                r_wd_cnt <= C_WD_LAST;
                stale    <= 1'b1;
            end else begin
                r_wd_cnt <= r_wd_cnt + TOW'(1);
            end

            dig_valid <= w_timeout ? 4'b0000 : w_valid_nx;
            upd       <= w_cap_upd || (w_timeout && (w_valid_nx != 4'b0000));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
//  Module      : tb_seg_scan_decoder
//  Description : Self-checking bench for seg_scan_decoder: directed vector
//                table, multi-cycle corner sequences and random traffic
//                against a run-length based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

    localparam int STB = 4;
    localparam int TMO = 16;
`ifdef SEG_DEC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int H = STB + LAT + 1;

    logic        clk1 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  an = 4'b0000;
    logic [7:0]  seg = 8'h00;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic [3:0]  dp_out;
    logic        upd;
    logic        err_pat;
    logic        err_an;
    logic        stale;

    seg_scan_decoder #(
        .STABLE_CYCLES  (STB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk1      (clk1),
        .reset     (reset),
        .an        (an),
        .seg       (seg),
        .digits    (digits),
        .dig_valid (dig_valid),
        .dp_out    (dp_out),
        .upd       (upd),
        .err_pat   (err_pat),
        .err_an    (err_an),
        .stale     (stale)
    );

    always #5 clk1 = ~clk1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] pat [10];

    // Reference model state
    logic [3:0]  m_dig [4];
    logic [3:0]  m_val;
    logic [3:0]  m_dp;
    logic        m_stale;
    int          m_since;
    int          m_run;
    logic [11:0] m_prev;
    logic [11:0] m_d1;
    logic [11:0] m_d2;
    logic        e_upd;
    logic        e_ea;
    logic        e_ep;

    logic        upd_seen;
    logic        ea_seen;
    logic        ep_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
        m_val   = 4'b0000;
        m_dp    = 4'b0000;
        m_stale = 1'b0;
        m_since = 0;
        m_run   = STB + 2;
        m_prev  = 12'h000;
        m_d1    = 12'h000;
        m_d2    = 12'h000;
        e_upd   = 1'b0;
        e_ea    = 1'b0;
        e_ep    = 1'b0;
    endtask

    // Capture happens on the edge where the bus has been seen unchanged for
    // STB edges after the edge that first showed it
    task automatic model_step();
        logic [11:0] x;
        int pos;
        int d;
        bit vcap;
`ifdef SEG_DEC_SYNC_EN
        x    = m_d2;
        m_d2 = m_d1;
        m_d1 = {an, seg};
`else
        x = {an, seg};
`endif
        e_upd = 1'b0;
        e_ea  = 1'b0;
        e_ep  = 1'b0;
        vcap  = 1'b0;
        if (x != m_prev) m_run = 1;
        else if (m_run < STB + 2) m_run++;
        m_prev = x;
        if (m_run == STB + 1 && x[11:8] != 4'b0000) begin
            if ($countones(x[11:8]) > 1) begin
                e_ea = 1'b1;
            end else begin
                pos = 0;
                for (int i = 0; i < 4; i++) if (x[11-i]) pos = i;
                d = -1;
                for (int k = 0; k < 10; k++) if (pat[k] == x[7:1]) d = k;
                if (d >= 0) begin
                    if (!m_val[pos] || m_dig[pos] != 4'(d)) e_upd = 1'b1;
                    m_dig[pos] = 4'(d);
                    m_val[pos] = 1'b1;
                    m_dp[pos]  = ~x[0];
                    vcap = 1'b1;
                end else begin
                    if (m_val[pos]) e_upd = 1'b1;
                    m_dig[pos] = 4'hF;
                    m_val[pos] = 1'b0;
                    if (x[7:1] != 7'h7F) e_ep = 1'b1;
                end
            end
        end
        if (vcap) m_since = 0;
        else if (m_since < TMO - 1) m_since++;
        if (!vcap && m_since == TMO - 1) begin
            if (m_val != 4'b0000) e_upd = 1'b1;
            m_val = 4'b0000;
        end
        m_stale = (m_since == TMO - 1);
    endtask

    task automatic tick();
        @(posedge clk1);
        if (!reset) model_step();
        #1;
        chk("digits",    32'(digits),    32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        chk("dig_valid", 32'(dig_valid), 32'(m_val));
        chk("dp_out",    32'(dp_out),    32'(m_dp));
        chk("upd",       32'(upd),       32'(e_upd));
        chk("err_an",    32'(err_an),    32'(e_ea));
        chk("err_pat",   32'(err_pat),   32'(e_ep));
        chk("stale",     32'(stale),     32'(m_stale));
        upd_seen = upd_seen | upd;
        ea_seen  = ea_seen | err_an;
        ep_seen  = ep_seen | err_pat;
    endtask

    task automatic run_window(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a;
        seg = s;
        upd_seen = 1'b0;
        ea_seen  = 1'b0;
        ep_seen  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_digits"},    32'(digits),    32'h0000FFFF);
        chk({tag, "_dig_valid"}, 32'(dig_valid), 32'h0);
        chk({tag, "_dp_out"},    32'(dp_out),    32'h0);
        chk({tag, "_pulses"},    32'({upd, err_pat, err_an}), 32'h0);
        chk({tag, "_stale"},     32'(stale),     32'h0);
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  dp;
        logic        upd;
        logic        ea;
        logic        ep;
    } vec_t;

    vec_t tab [13];

    initial begin
        logic [3:0] ra;
        logic [7:0] rs;
        int sel;
        int hold;

        pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010;
        pat[3] = 7'b0000110; pat[4] = 7'b1001100; pat[5] = 7'b0100100;
        pat[6] = 7'b0100000; pat[7] = 7'b0001111; pat[8] = 7'b0000000;
        pat[9] = 7'b0000100;

        tab[0]  = '{4'b1000, 8'b01001001, 16'hFFF5, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0};
        tab[1]  = '{4'b0100, 8'b10011111, 16'hFF15, 4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0};
        tab[2]  = '{4'b1000, 8'b01001000, 16'hFF15, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0};
        tab[3]  = '{4'b1100, 8'b00000001, 16'hFF15, 4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0};
        tab[4]  = '{4'b0010, 8'b00001000, 16'hF915, 4'b0111, 4'b0101, 1'b1, 1'b0, 1'b0};
        tab[5]  = '{4'b1000, 8'b11000001, 16'hF91F, 4'b0110, 4'b0101, 1'b1, 1'b0, 1'b1};
        tab[6]  = '{4'b0001, 8'b00011111, 16'h791F, 4'b1110, 4'b0101, 1'b1, 1'b0, 1'b0};
        tab[7]  = '{4'b0001, 8'b11111111, 16'hF91F, 4'b0110, 4'b0101, 1'b1, 1'b0, 1'b0};
        tab[8]  = '{4'b1000, 8'b00000011, 16'hF910, 4'b0111, 4'b0100, 1'b1, 1'b0, 1'b0};
        tab[9]  = '{4'b0100, 8'b11111110, 16'hF9F0, 4'b0101, 4'b0100, 1'b1, 1'b0, 1'b0};
        tab[10] = '{4'b0100, 8'b00100101, 16'hF920, 4'b0111, 4'b0100, 1'b1, 1'b0, 1'b0};
        tab[11] = '{4'b0000, 8'b00000000, 16'hF920, 4'b0111, 4'b0100, 1'b0, 1'b0, 1'b0};
        tab[12] = '{4'b1000, 8'b01000001, 16'hF926, 4'b0111, 4'b0100, 1'b1, 1'b0, 1'b0};

        model_reset();
        upd_seen = 1'b0;
        ea_seen  = 1'b0;
        ep_seen  = 1'b0;

        // Power-on reset
        tick();
        tick();
        chk_reset_values("por");
        #3 reset = 1'b0;

        // Directed vector table; each window ends on the capture edge
        for (int v = 0; v < 13; v++) begin
            run_window(tab[v].an, tab[v].seg, H);
            chk($sformatf("vec%0d_digits", v), 32'(digits),    32'(tab[v].digits));
            chk($sformatf("vec%0d_valid", v),  32'(dig_valid), 32'(tab[v].valid));
            chk($sformatf("vec%0d_dp", v),     32'(dp_out),    32'(tab[v].dp));
            chk($sformatf("vec%0d_upd", v),    32'(upd_seen),  32'(tab[v].upd));
            chk($sformatf("vec%0d_err_an", v), 32'(ea_seen),   32'(tab[v].ea));
            chk($sformatf("vec%0d_err_pat", v),32'(ep_seen),   32'(tab[v].ep));
        end

        // Refresh stops: stale exactly TMO-1 cycles after the last capture
        run_window(4'b0000, 8'hFF, TMO - 2);
        chk("wd_pre_stale", 32'(stale), 32'h0);
        chk("wd_pre_valid", 32'(dig_valid), 32'h7);
        chk("wd_pre_upd", 32'(upd_seen), 32'h0);
        tick();
        chk("wd_stale", 32'(stale), 32'h1);
        chk("wd_valid", 32'(dig_valid), 32'h0);
        chk("wd_upd", 32'(upd), 32'h1);
        run_window(4'b0100, 8'b00001101, H);
        chk("wd_recover_stale", 32'(stale), 32'h0);
        chk("wd_recover_valid", 32'(dig_valid), 32'h2);
        chk("wd_recover_digits", 32'(digits), 32'hF936);
        chk("wd_recover_upd", 32'(upd), 32'h1);

        // Pattern changes every 3 cycles never settle
        upd_seen = 1'b0;
        ea_seen  = 1'b0;
        ep_seen  = 1'b0;
        an = 4'b0010;
        for (int t = 0; t < 4; t++) begin
            seg = (t % 2 == 0) ? 8'b10011001 : 8'b00100101;
            repeat (3) tick();
        end
        chk("toggle_no_upd", 32'({upd_seen, ea_seen, ep_seen}), 32'h0);
        chk("toggle_digits", 32'(digits), 32'hF936);

        // Reset while settling discards the pending capture
        #3 reset = 1'b1;
        model_reset();
        #1 chk_reset_values("mid_settle");
        an  = 4'b0000;
        seg = 8'h00;
        tick();
        #3 reset = 1'b0;
        upd_seen = 1'b0;
        repeat (10) tick();
        chk("post_reset_idle_upd", 32'(upd_seen), 32'h0);
        chk("post_reset_idle_digits", 32'(digits), 32'h0000FFFF);

        // Random traffic against the model
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 9);
            ra = 4'b1000 >> $urandom_range(0, 3);
            rs = {pat[$urandom_range(0, 9)], 1'($urandom_range(0, 1))};
            case (sel)
                0: ra = 4'b0000;
                1: begin
                    ra = 4'($urandom_range(0, 15));
                    while ($countones(ra) < 2) ra = 4'($urandom_range(0, 15));
                end
                2: rs = {7'b1111111, 1'($urandom_range(0, 1))};
                3: rs = 8'($urandom);
                default: ;
            endcase
            hold = ($urandom_range(0, 14) == 0) ? 20 : $urandom_range(1, 7);
            an  = ra;
            seg = rs;
            repeat (hold) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
